// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Round-robin arbiter sharing one N-bit ALU between two
//               requesters; holds operands for LAT cycles, then returns BusW.
//               Optional illegal-op rejection when ALU_ILLEGAL_OP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
  parameter int N   = 64,
  parameter int LAT = 3
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [3:0]   op0,
  input  logic [3:0]   op1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [N-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic [3:0]   alu_ctrl,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_w
);

  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_ptr;
  logic           r_owner;
  logic           r_ill_pend;
  logic           r_gnt0, r_gnt1, r_done0, r_done1;
  logic [3:0]     r_ctrl;
  logic [N-1:0]   r_a, r_b, r_data;
  logic           r_zero, r_err;

  logic           w_any, w_pick1, w_legal;
  logic [3:0]     w_op;
  logic [N-1:0]   w_a, w_b;

  // r_ptr == 1 gives requester 1 priority when both request together.
  assign w_any   = req0 | req1;
  assign w_pick1 = req1 & (~req0 | r_ptr);
  assign w_op    = w_pick1 ? op1 : op0;
  assign w_a     = w_pick1 ? a1  : a0;
  assign w_b     = w_pick1 ? b1  : b0;

`ifdef ALU_ILLEGAL_OP_EN
  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0110, 4'b0111: w_legal = 1'b1;
      default:                   w_legal = 1'b0;
    endcase
  end
`else
  assign w_legal = 1'b1;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_ill_pend <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_ctrl     <= 4'b0000;
      r_a        <= '0;
      r_b        <= '0;
      r_data     <= '0;
      r_zero     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_owner <= w_pick1;
            r_ptr   <= ~w_pick1;
            if (w_legal) begin
              r_ctrl  <= w_op;
              r_a     <= w_a;
              r_b     <= w_b;
              r_cnt   <= CW'(LAT);
              r_state <= S_BUSY;
            end else begin
              // Rejected op: one RESP cycle to let gnt show before done.
              r_ill_pend <= 1'b1;
              r_state    <= S_RESP;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_data  <= alu_w;
            r_zero  <= (alu_w == '0);
            r_err   <= 1'b0;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (r_ill_pend) begin
            r_ill_pend <= 1'b0;
            r_data     <= '0;
            r_zero     <= 1'b0;
            r_err      <= 1'b1;
            r_done0    <= ~r_owner;
            r_done1    <= r_owner;
          end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign rsp_data = r_data;
  assign rsp_zero = r_zero;
  assign rsp_err  = r_err;
  assign alu_ctrl = r_ctrl;
  assign alu_a    = r_a;
  assign alu_b    = r_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Directed self-checking bench for alu_share_ctrl with a
//               behavioural ALU on BusW.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

  localparam int N   = 64;
  localparam int LAT = 3;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [3:0]   op0 = '0, op1 = '0;
  logic [N-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic         gnt0, gnt1, done0, done1;
  logic [N-1:0] rsp_data;
  logic         rsp_zero, rsp_err;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_a, alu_b, alu_w;

  alu_share_ctrl #(.N(N), .LAT(LAT)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_w(alu_w)
  );

  always #5 CLK = ~CLK;

  function automatic logic [N-1:0] alu_model(input logic [3:0] c,
                                             input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return '0;
    endcase
  endfunction

  assign alu_w = alu_model(alu_ctrl, alu_a, alu_b);

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int both  = 0;
  int           g_id[$], g_cyc[$], d_id[$], d_cyc[$];
  logic [N-1:0] d_data[$];
  logic         d_zero[$], d_err[$];

  // Event log sampled 1 time unit after each rising edge.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (gnt0)  begin g_id.push_back(0); g_cyc.push_back(cyc); end
    if (gnt1)  begin g_id.push_back(1); g_cyc.push_back(cyc); end
    if (done0 || done1) begin
      d_id.push_back(done1 ? 1 : 0); d_cyc.push_back(cyc);
      d_data.push_back(rsp_data); d_zero.push_back(rsp_zero); d_err.push_back(rsp_err);
    end
    if ((gnt0 && gnt1) || (done0 && done1)) both++;
  end

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic clear_log();
    g_id.delete(); g_cyc.delete(); d_id.delete(); d_cyc.delete();
    d_data.delete(); d_zero.delete(); d_err.delete(); both = 0;
  endtask

  task automatic wait_gnts(input int n, input int budget);
    for (int i = 0; i < budget && g_id.size() < n; i++) tick();
  endtask

  task automatic wait_dones(input int n, input int budget);
    for (int i = 0; i < budget && d_id.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    clear_log();
    req0 = 1'b1; op0 = 4'b0010; a0 = 64'd5; b0 = 64'd7;
    wait_gnts(1, 10);
    req0 = 1'b0;
    tick();
    #1 Reset = 1'b1;
    #1;
    n_cmp++; if (alu_ctrl !== 4'b0000) begin n_bad++; $display("FAIL rst_alu_ctrl: got %b want 0000", alu_ctrl); end
    n_cmp++; if ({alu_a, alu_b} !== '0) begin n_bad++; $display("FAIL rst_alu_ab: got %h/%h want 0/0", alu_a, alu_b); end
    n_cmp++; if ({gnt0, gnt1, done0, done1} !== 4'b0) begin n_bad++; $display("FAIL rst_handshake: got %b want 0000", {gnt0, gnt1, done0, done1}); end
    n_cmp++; if ({rsp_data, rsp_zero, rsp_err} !== '0) begin n_bad++; $display("FAIL rst_rsp: got %h/%b/%b want 0/0/0", rsp_data, rsp_zero, rsp_err); end
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single_add();
    int t0;
    clear_log();
    t0 = cyc;
    req0 = 1'b1; op0 = 4'b0010; a0 = 64'd5; b0 = 64'd7;
    wait_gnts(1, 10);
    req0 = 1'b0;
    wait_dones(1, 20);
    tick(); tick();
    n_cmp++; if (g_id.size() !== 1 || d_id.size() !== 1) begin
      n_bad++; $display("FAIL add_counts: got gnt=%0d done=%0d want 1/1", g_id.size(), d_id.size());
    end else begin
      n_cmp++; if (g_id[0] !== 0 || g_cyc[0] - t0 !== 1) begin n_bad++; $display("FAIL add_gnt: got id=%0d lat=%0d want 0/1", g_id[0], g_cyc[0] - t0); end
      n_cmp++; if (d_id[0] !== 0 || d_cyc[0] - g_cyc[0] !== LAT) begin n_bad++; $display("FAIL add_done: got id=%0d lat=%0d want 0/%0d", d_id[0], d_cyc[0] - g_cyc[0], LAT); end
      n_cmp++; if (d_data[0] !== 64'd12 || d_zero[0] !== 1'b0 || d_err[0] !== 1'b0) begin n_bad++; $display("FAIL add_rsp: got %0d/%b/%b want 12/0/0", d_data[0], d_zero[0], d_err[0]); end
    end
    n_cmp++; if (rsp_data !== 64'd12) begin n_bad++; $display("FAIL add_hold_rsp: got %0d want 12", rsp_data); end
    n_cmp++; if (alu_ctrl !== 4'b0010 || alu_a !== 64'd5 || alu_b !== 64'd7) begin n_bad++; $display("FAIL add_hold_alu: got %b/%0d/%0d want 0010/5/7", alu_ctrl, alu_a, alu_b); end
  endtask

  task automatic test_sub_zero();
    int t0;
    clear_log();
    t0 = cyc;
    req1 = 1'b1; op1 = 4'b0110; a1 = 64'd9; b1 = 64'd9;
    wait_gnts(1, 10);
    req1 = 1'b0;
    wait_dones(1, 20);
    tick(); tick();
    n_cmp++; if (g_id.size() !== 1 || d_id.size() !== 1) begin
      n_bad++; $display("FAIL sub_counts: got gnt=%0d done=%0d want 1/1", g_id.size(), d_id.size());
    end else begin
      n_cmp++; if (g_id[0] !== 1 || g_cyc[0] - t0 !== 1) begin n_bad++; $display("FAIL sub_gnt: got id=%0d lat=%0d want 1/1", g_id[0], g_cyc[0] - t0); end
      n_cmp++; if (d_id[0] !== 1 || d_cyc[0] - g_cyc[0] !== LAT) begin n_bad++; $display("FAIL sub_done: got id=%0d lat=%0d want 1/%0d", d_id[0], d_cyc[0] - g_cyc[0], LAT); end
      n_cmp++; if (d_data[0] !== 64'd0 || d_zero[0] !== 1'b1) begin n_bad++; $display("FAIL sub_rsp: got %0d/%b want 0/1", d_data[0], d_zero[0]); end
    end
  endtask

  task automatic test_contention();
    int exp_id[4]   = '{0, 1, 0, 1};
    int exp_data[4] = '{2, 6, 2, 6};
    clear_log();
    op0 = 4'b0010; a0 = 64'd1; b0 = 64'd1;
    op1 = 4'b0001; a1 = 64'd4; b1 = 64'd2;
    req0 = 1'b1; req1 = 1'b1;
    wait_dones(4, 60);
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (g_id.size() !== 4 || d_id.size() !== 4) begin
      n_bad++; $display("FAIL cont_counts: got gnt=%0d done=%0d want 4/4", g_id.size(), d_id.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (g_id[i] !== exp_id[i] || d_id[i] !== exp_id[i]) begin n_bad++; $display("FAIL cont_order[%0d]: got gnt=%0d done=%0d want %0d", i, g_id[i], d_id[i], exp_id[i]); end
        n_cmp++; if (d_data[i] !== 64'(exp_data[i])) begin n_bad++; $display("FAIL cont_data[%0d]: got %0d want %0d", i, d_data[i], exp_data[i]); end
        if (i > 0) begin
          n_cmp++; if (g_cyc[i] - g_cyc[i-1] !== LAT + 2) begin n_bad++; $display("FAIL cont_interval[%0d]: got %0d want %0d", i, g_cyc[i] - g_cyc[i-1], LAT + 2); end
        end
      end
    end
    n_cmp++; if (both !== 0) begin n_bad++; $display("FAIL cont_exclusive: got %0d overlaps want 0", both); end
  endtask

  task automatic test_reset_busy();
    int t0;
    clear_log();
    req0 = 1'b1; op0 = 4'b0010; a0 = 64'd1; b0 = 64'd2;
    wait_gnts(1, 10);
    req0 = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    clear_log();
    for (int i = 0; i < LAT + 3; i++) tick();
    n_cmp++; if (d_id.size() !== 0 || g_id.size() !== 0) begin n_bad++; $display("FAIL rbusy_no_done: got done=%0d gnt=%0d want 0/0", d_id.size(), g_id.size()); end
    clear_log();
    t0 = cyc;
    op0 = 4'b0010; a0 = 64'd3; b0 = 64'd4;
    op1 = 4'b0001; a1 = 64'd4; b1 = 64'd2;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnts(1, 10);
    req0 = 1'b0;
    wait_dones(1, 20);
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (g_id.size() !== 1 || d_id.size() !== 1) begin
      n_bad++; $display("FAIL rbusy_counts: got gnt=%0d done=%0d want 1/1", g_id.size(), d_id.size());
    end else begin
      n_cmp++; if (g_id[0] !== 0 || g_cyc[0] - t0 !== 1) begin n_bad++; $display("FAIL rbusy_gnt: got id=%0d lat=%0d want 0/1", g_id[0], g_cyc[0] - t0); end
      n_cmp++; if (d_cyc[0] - g_cyc[0] !== LAT || d_data[0] !== 64'd7) begin n_bad++; $display("FAIL rbusy_rsp: got lat=%0d data=%0d want %0d/7", d_cyc[0] - g_cyc[0], d_data[0], LAT); end
    end
  endtask

  task automatic test_illegal();
    clear_log();
    req0 = 1'b1; op0 = 4'b1000; a0 = 64'd11; b0 = 64'd13;
    wait_gnts(1, 10);
    req0 = 1'b0;
    wait_dones(1, 20);
    tick(); tick();
    n_cmp++; if (g_id.size() !== 1 || d_id.size() !== 1) begin
      n_bad++; $display("FAIL ill_counts: got gnt=%0d done=%0d want 1/1", g_id.size(), d_id.size());
    end else begin
`ifdef ALU_ILLEGAL_OP_EN
      n_cmp++; if (d_id[0] !== 0 || d_cyc[0] - g_cyc[0] !== 1) begin n_bad++; $display("FAIL ill_lat: got id=%0d lat=%0d want 0/1", d_id[0], d_cyc[0] - g_cyc[0]); end
      n_cmp++; if (d_err[0] !== 1'b1 || d_data[0] !== 64'd0 || d_zero[0] !== 1'b0) begin n_bad++; $display("FAIL ill_rsp: got err=%b data=%0d zero=%b want 1/0/0", d_err[0], d_data[0], d_zero[0]); end
      n_cmp++; if (alu_ctrl !== 4'b0010 || alu_a !== 64'd3) begin n_bad++; $display("FAIL ill_alu_hold: got %b/%0d want 0010/3", alu_ctrl, alu_a); end
`else
      n_cmp++; if (d_id[0] !== 0 || d_cyc[0] - g_cyc[0] !== LAT) begin n_bad++; $display("FAIL ill_lat: got id=%0d lat=%0d want 0/%0d", d_id[0], d_cyc[0] - g_cyc[0], LAT); end
      n_cmp++; if (d_err[0] !== 1'b0 || d_data[0] !== 64'd0 || d_zero[0] !== 1'b1) begin n_bad++; $display("FAIL ill_rsp: got err=%b data=%0d zero=%b want 0/0/1", d_err[0], d_data[0], d_zero[0]); end
      n_cmp++; if (alu_ctrl !== 4'b1000 || alu_a !== 64'd11) begin n_bad++; $display("FAIL ill_alu_fwd: got %b/%0d want 1000/11", alu_ctrl, alu_a); end
`endif
    end
  endtask

  initial begin
    tick(); tick();
    Reset = 1'b0;
    tick();
    test_reset();
    test_single_add();
    test_sub_zero();
    test_contention();
    test_reset_busy();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin controller that shares one 64-bit ALU instance between two requesters, for example an execute stage and an address-generation unit.
- Accepts one operation at a time, then drives the ALU's ALUCtrl, BusA and BusB from registered copies of the request.
- Waits a fixed settle time, captures BusW and returns the result with a one-cycle done pulse to the requester that issued it.

Parameters:
- N, 64: datapath width. Matches the ALU's n.
- LAT, 3: cycles the ALU inputs are held before BusW is captured. Must be >= 1.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req0, req1  input  1 each  operation request from requester 0 / 1.
- op0, op1  input  4 each  ALUCtrl code for requester 0 / 1.
- a0, a1  input  N each  BusA operand for requester 0 / 1.
- b0, b1  input  N each  BusB operand for requester 0 / 1.
- gnt0, gnt1  output  1 each  one-cycle pulse: request was accepted.
- done0, done1  output  1 each  one-cycle pulse: result is valid for that requester.
- rsp_data  output  N  captured BusW.
- rsp_zero  output  1  1 when rsp_data == 0, computed locally.
- rsp_err  output  1  illegal-op flag; see Optional Feature.
- alu_ctrl  output  4  to ALU ALUCtrl.
- alu_a, alu_b  output  N  to ALU BusA / BusB.
- alu_w  input  N  from ALU BusW.

Behaviour:
- Clocking and reset:
  - One clock domain: CLK. Reset is asynchronous and active-high.
  - On Reset, every output and register is cleared to 0: gnt*, done*, rsp_*, alu_ctrl = 4'b0000, alu_a/alu_b, LAT counter, state = IDLE, priority pointer = requester 0.
  - Reset mid-operation discards the in-flight operation. No done pulse is issued for it.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Samples req0/req1 at each edge.
  - If exactly one is high, that requester wins. If both are high, the priority pointer wins.
  - On the accepting edge: latch the winner's op, a and b into alu_ctrl/alu_a/alu_b; set the matching gnt high for the next cycle only; load counter = LAT; go to BUSY; point the pointer at the other requester.
  - If neither request is high, stay in IDLE.
- BUSY:
  - alu_* are held constant and the counter decrements each edge.
  - On the edge where counter == 1: rsp_data <= alu_w; rsp_zero <= (alu_w == 0); rsp_err <= 0; go to RESP.
- RESP:
  - done of the owning requester is high for exactly one cycle; rsp_* are valid in that cycle. Then go to IDLE.
  - No new request is accepted in RESP.
- Latency:
  - gnt is high in cycle k+1 after an accepting edge k.
  - done is high in cycle k+1+LAT.
  - Issue interval is LAT+2 cycles.
- Holding outputs:
  - rsp_* hold their values after done until the next capture.
  - alu_* hold the last issued operation while in IDLE.
- Requester rules:
  - op/a/b must be stable while req is high and not yet granted.
  - A req still high at the next IDLE sample is treated as a new operation, using the operand values present at that sample.
- Width rules: operands and the result are passed through unmodified at N bits. The controller does no arithmetic except the zero compare.
- gnt0/gnt1 are never high together, and neither are done0/done1.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_EN.
- Defined:
  - Legal codes are 0000, 0001, 0010, 0011, 0100, 0110, 0111.
  - An accepted illegal op still gets gnt, but alu_* are not updated and the FSM goes IDLE -> RESP directly, skipping BUSY.
  - In that RESP cycle: done = 1, rsp_err = 1, rsp_data = 0, rsp_zero = 0. The done pulse appears one cycle after gnt.
  - The priority pointer still advances.
- Undefined:
  - Every code is forwarded to the ALU with the full LAT wait.
  - rsp_err is constant 0.

Test Plan:
- Reset: assert Reset asynchronously mid-cycle -> all outputs read 0 immediately; alu_ctrl = 4'b0000.
- Single ADD: req0 with op0 = 0010, a0 = 5, b0 = 7 (LAT = 3) -> gnt0 pulses one cycle, done0 three cycles later, rsp_data = 12, rsp_zero = 0, done1 stays 0.
- SUB zero: req1 with op1 = 0110, a1 = 9, b1 = 9 -> done1 pulse, rsp_data = 0, rsp_zero = 1.
- Contention: req0 and req1 held high continuously, ops ADD 1+1 and OR 4|2 -> grant order 0,1,0,1 with one grant every 5 cycles; done order matches; rsp_data alternates 2 and 6.
- Reset in BUSY: assert Reset two cycles after gnt0 -> no done0; after release, a new ADD 3+4 returns 7 with nominal latency; first grant goes to requester 0.
- Illegal op 1000 from req0: with ALU_ILLEGAL_OP_EN -> done0 one cycle after gnt0, rsp_err = 1, rsp_data = 0, alu_ctrl unchanged; without the macro -> rsp_err = 0 and done0 arrives LAT cycles after gnt0.
